alu_exec_pipe: RTL and testbench
================================

Name: alu_exec_pipe

Overview:
- Execute-stage wrapper around the combinational ALU.
- Stage 1 (S1) is an operand/control register. It takes decoded operations from the decode stage over a valid/ready handshake and drives the ALU's zx/nx/zy/ny/f/no, x, y and enable inputs.
- Stage 2 (S2) captures the ALU result with zero/negative flags and destination tag, then hands it to writeback over a second valid/ready handshake.
- Provides one-entry result forwarding so back-to-back dependent ops issue without stalling.

Parameters:
- W, 16, datapath width; must equal the ALU width.
- TAGW, 3, destination register tag width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  decode presents an op
- in_ready  output  1  S1 can accept this cycle
- in_op  input  6  {zx,nx,zy,ny,f,no}, bit5 = zx … bit0 = no
- in_x  input  W  operand x
- in_y  input  W  operand y
- in_fwd_x  input  1  replace in_x with the most recent result
- in_fwd_y  input  1  replace in_y with the most recent result
- in_dst  input  TAGW  destination tag
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  output  1 each  ALU control bits
- alu_x  output  W  ALU operand x
- alu_y  output  W  ALU operand y
- alu_enable  output  1  ALU enable
- alu_out  input  W  combinational ALU result
- out_valid  output  1  S2 holds a result
- out_ready  input  1  writeback accepts
- out_data  output  W  result
- out_dst  output  TAGW  destination tag
- out_zr  output  1  out_data == 0
- out_ng  output  1  out_data[W-1]
- op_count  output  16  ops retired (S2 handshakes), wraps at 0xFFFF -> 0

Behaviour:
- Reset (rst_n low at a clk edge) clears: S1/S2 valid, every S1/S2 register, last-result register, op_count.
- After reset: in_ready = 1, out_valid = 0, all data/control outputs 0.
- Reset mid-operation discards in-flight ops; nothing is retired.
- Advance conditions:
  - s2_adv = S1 valid & (!S2 valid | out_ready).
  - s1_load = in_valid & in_ready.
  - in_ready = !S1 valid | s2_adv. This is a combinational path from out_ready; it is intended.
- S1 load:
  - Registers in_op and in_dst.
  - x operand = in_fwd_x ? fwd_val : in_x; y operand likewise with in_fwd_y.
  - If !s1_load and s2_adv: S1 goes invalid. Otherwise S1 holds its contents.
- ALU drive:
  - alu_* come straight from S1 registers.
  - alu_enable = S1 valid, so the ALU outputs 0 when S1 is empty.
- S2 capture on s2_adv: out_data ← alu_out, out_dst ← S1 dst, out_zr/out_ng from alu_out, S2 valid ← 1.
- S2 release: on out_valid & out_ready & !s2_adv, S2 goes invalid. Outputs hold stable while out_valid & !out_ready.
- fwd_val priority (most recent first):
  1. alu_out, if S1 valid (the op ahead is still in S1).
  2. else S2 data, if S2 valid.
  3. else the last-result register, updated whenever S2 captures.
- Throughput and latency:
  - One op per cycle when out_ready is held high.
  - Latency: in handshake cycle N gives out_valid at cycle N+2.
- Simultaneous load into S1 and advance out of S1 in the same cycle is legal; no bubble.
- op_count increments on out_valid & out_ready; 16-bit modular wrap.
- Data under backpressure is never lost or duplicated. With out_ready = 0, at most 2 ops are held and in_ready drops to 0.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, op_count=0, alu_enable=0. The first op after release is the first one out.
- Add: op 000010, x=0x0005, y=0x0003, dst=2 -> two cycles later out_data=0x0008, out_dst=2, zr=0, ng=0, op_count=1.
- Subtract and constants: op 010011 (x−y), x=0x0003, y=0x0005 -> 0xFFFE, ng=1. Then op 101010 -> 0x0000, zr=1. Then op 111010 -> 0xFFFF, ng=1.
- Forwarding: op A = add 0x0001+0x0001, immediately followed by op B = add with in_fwd_x=1, y=0x0010 -> B result 0x0012 with no stall. Repeat with a one-cycle bubble between A and B -> same 0x0012.
- Backpressure: out_ready=0, issue 3 ops -> in_ready=0 after 2 accepted, S2 output stable. Raise out_ready -> results emerge in order, one per cycle, op_count=3.
- Wrap and reset mid-flight: preload op_count via 65536 retirements -> op_count reads 0. Assert rst_n=0 with 2 ops in flight -> out_valid=0 next cycle and no extra retirement.

Source files
------------

// File: rtl/alu_exec_pipe.sv
// Execute stage around the combinational ALU: operand register (S1),
// result register (S2) and one-entry result forwarding.
module alu_exec_pipe #(
    parameter int W    = 16,
    parameter int TAGW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      in_op,
    input  logic [W-1:0]    in_x,
    input  logic [W-1:0]    in_y,
    input  logic            in_fwd_x,
    input  logic            in_fwd_y,
    input  logic [TAGW-1:0] in_dst,
    output logic            alu_zx,
    output logic            alu_nx,
    output logic            alu_zy,
    output logic            alu_ny,
    output logic            alu_f,
    output logic            alu_no,
    output logic [W-1:0]    alu_x,
    output logic [W-1:0]    alu_y,
    output logic            alu_enable,
    input  logic [W-1:0]    alu_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [TAGW-1:0] out_dst,
    output logic            out_zr,
    output logic            out_ng,
    output logic [15:0]     op_count
);

    logic            s1_valid_q, s1_valid_d;
    logic [5:0]      s1_op_q, s1_op_d;
    logic [W-1:0]    s1_x_q, s1_x_d;
    logic [W-1:0]    s1_y_q, s1_y_d;
    logic [TAGW-1:0] s1_dst_q, s1_dst_d;

    logic            s2_valid_q, s2_valid_d;
    logic [W-1:0]    s2_data_q, s2_data_d;
    logic [TAGW-1:0] s2_dst_q, s2_dst_d;
    logic            s2_zr_q, s2_zr_d;
    logic            s2_ng_q, s2_ng_d;

    logic [W-1:0]    last_q, last_d;
    logic [15:0]     cnt_q, cnt_d;

    logic            s2_adv;
    logic            s1_load;
    logic [W-1:0]    fwd_val;

    // in_ready deliberately depends combinationally on out_ready
    always_comb begin
        s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
        in_ready = ~s1_valid_q | s2_adv;
        s1_load  = in_valid & in_ready;
    end

    // Youngest result wins: op in S1, then S2, then last retired
    always_comb begin
        if (s1_valid_q)
            fwd_val = alu_out;
        else if (s2_valid_q)
            fwd_val = s2_data_q;
        else
            fwd_val = last_q;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_dst_d   = s1_dst_q;
        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_op_d    = in_op;
            s1_x_d     = in_fwd_x ? fwd_val : in_x;
            s1_y_d     = in_fwd_y ? fwd_val : in_y;
            s1_dst_d   = in_dst;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_dst_d   = s2_dst_q;
        s2_zr_d    = s2_zr_q;
        s2_ng_d    = s2_ng_q;
        last_d     = last_q;
        if (s2_adv) begin
            s2_valid_d = 1'b1;
            s2_data_d  = alu_out;
            s2_dst_d   = s1_dst_q;
            s2_zr_d    = (alu_out == '0);
            s2_ng_d    = alu_out[W-1];
            last_d     = alu_out;
        end else if (s2_valid_q & out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (s2_valid_q & out_ready)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_dst_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_dst_q   <= '0;
            s2_zr_q    <= 1'b0;
            s2_ng_q    <= 1'b0;
            last_q     <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_dst_q   <= s1_dst_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_dst_q   <= s2_dst_d;
            s2_zr_q    <= s2_zr_d;
            s2_ng_q    <= s2_ng_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
        end
    end

    assign alu_zx     = s1_op_q[5];
    assign alu_nx     = s1_op_q[4];
    assign alu_zy     = s1_op_q[3];
    assign alu_ny     = s1_op_q[2];
    assign alu_f      = s1_op_q[1];
    assign alu_no     = s1_op_q[0];
    assign alu_x      = s1_x_q;
    assign alu_y      = s1_y_q;
    assign alu_enable = s1_valid_q;

    assign out_valid  = s2_valid_q;
    assign out_data   = s2_data_q;
    assign out_dst    = s2_dst_q;
    assign out_zr     = s2_zr_q;
    assign out_ng     = s2_ng_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed bench for alu_exec_pipe with a behavioural ALU attached.
module tb_alu_exec_pipe;

    localparam int W    = 16;
    localparam int TAGW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [5:0]      in_op;
    logic [W-1:0]    in_x, in_y;
    logic            in_fwd_x, in_fwd_y;
    logic [TAGW-1:0] in_dst;
    logic            alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic [W-1:0]    alu_x, alu_y;
    logic            alu_enable;
    logic [W-1:0]    alu_out;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic [TAGW-1:0] out_dst;
    logic            out_zr, out_ng;
    logic [15:0]     op_count;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    alu_exec_pipe #(.W(W), .TAGW(TAGW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_x(in_x), .in_y(in_y),
        .in_fwd_x(in_fwd_x), .in_fwd_y(in_fwd_y), .in_dst(in_dst),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy),
        .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
        .alu_x(alu_x), .alu_y(alu_y), .alu_enable(alu_enable),
        .alu_out(alu_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_dst(out_dst),
        .out_zr(out_zr), .out_ng(out_ng), .op_count(op_count)
    );

    // Hack-style ALU standing in for the real combinational unit
    logic [W-1:0] ax, ay, ar;
    always_comb begin
        ax = alu_zx ? '0 : alu_x;
        ax = alu_nx ? ~ax : ax;
        ay = alu_zy ? '0 : alu_y;
        ay = alu_ny ? ~ay : ay;
        ar = alu_f ? ax + ay : ax & ay;
        ar = alu_no ? ~ar : ar;
        alu_out = alu_enable ? ar : '0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [15:0] x,
                         input logic [15:0] y, input logic fx,
                         input logic fy, input logic [2:0] dst);
        in_valid = 1'b1;
        in_op    = op;
        in_x     = x;
        in_y     = y;
        in_fwd_x = fx;
        in_fwd_y = fy;
        in_dst   = dst;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_fwd_x = 1'b0;
        in_fwd_y = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(6'b000010, 16'h00AA, 16'h0055, 1'b0, 1'b0, 3'd7);

        // reset with in_valid held high
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_alu_en", 32'(alu_enable), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);

        // add 5+3 is the first op out after release
        rst_n = 1'b1;
        drive(6'b000010, 16'h0005, 16'h0003, 1'b0, 1'b0, 3'd2);
        tick();
        idle();
        chk("add_s1_en", 32'(alu_enable), 32'd1);
        chk("add_not_yet", 32'(out_valid), 32'd0);
        tick();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_data", 32'(out_data), 32'h0008);
        chk("add_dst", 32'(out_dst), 32'd2);
        chk("add_flags", {30'd0, out_zr, out_ng}, 32'd0);
        tick();
        chk("add_count", 32'(op_count), 32'd1);
        chk("add_drained", 32'(out_valid), 32'd0);

        // x-y, zero, minus one back to back
        drive(6'b010011, 16'h0003, 16'h0005, 1'b0, 1'b0, 3'd3);
        tick();
        drive(6'b101010, 16'h1234, 16'h5678, 1'b0, 1'b0, 3'd4);
        tick();
        chk("sub_data", 32'(out_data), 32'hFFFE);
        chk("sub_flags", {30'd0, out_zr, out_ng}, 32'b01);
        drive(6'b111010, 16'h1234, 16'h5678, 1'b0, 1'b0, 3'd5);
        tick();
        idle();
        chk("zero_data", 32'(out_data), 32'h0000);
        chk("zero_flags", {30'd0, out_zr, out_ng}, 32'b10);
        chk("zero_dst", 32'(out_dst), 32'd4);
        tick();
        chk("m1_data", 32'(out_data), 32'hFFFF);
        chk("m1_flags", {30'd0, out_zr, out_ng}, 32'b01);
        tick();
        chk("const_count", 32'(op_count), 32'd4);

        // forwarding from S1, no stall
        drive(6'b000010, 16'h0001, 16'h0001, 1'b0, 1'b0, 3'd1);
        tick();
        drive(6'b000010, 16'h7777, 16'h0010, 1'b1, 1'b0, 3'd2);
        #1;
        chk("fwd_ready", 32'(in_ready), 32'd1);
        tick();
        idle();
        chk("fwdA_data", 32'(out_data), 32'h0002);
        tick();
        chk("fwdB_data", 32'(out_data), 32'h0012);
        chk("fwdB_dst", 32'(out_dst), 32'd2);
        tick();

        // forwarding from S2 after a bubble, via y
        drive(6'b000010, 16'h0001, 16'h0001, 1'b0, 1'b0, 3'd1);
        tick();
        idle();
        tick();
        drive(6'b000010, 16'h0010, 16'h7777, 1'b0, 1'b1, 3'd3);
        tick();
        idle();
        tick();
        chk("bub_data", 32'(out_data), 32'h0012);
        chk("bub_dst", 32'(out_dst), 32'd3);
        tick();
        chk("fwd_count", 32'(op_count), 32'd8);

        // backpressure: 3 ops, only 2 held
        do_reset();
        out_ready = 1'b0;
        drive(6'b000010, 16'h0001, 16'h0000, 1'b0, 1'b0, 3'd1);
        #1;
        chk("bp_rdy1", 32'(in_ready), 32'd1);
        tick();
        drive(6'b000010, 16'h0002, 16'h0000, 1'b0, 1'b0, 3'd2);
        #1;
        chk("bp_rdy2", 32'(in_ready), 32'd1);
        tick();
        drive(6'b000010, 16'h0003, 16'h0000, 1'b0, 1'b0, 3'd3);
        #1;
        chk("bp_rdy3", 32'(in_ready), 32'd0);
        tick();
        tick();
        chk("bp_hold_v", 32'(out_valid), 32'd1);
        chk("bp_hold_d", 32'(out_data), 32'h0001);
        chk("bp_hold_t", 32'(out_dst), 32'd1);
        chk("bp_no_ret", 32'(op_count), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_comb", 32'(in_ready), 32'd1);
        tick();
        idle();
        chk("bp_o2", 32'(out_data), 32'h0002);
        tick();
        chk("bp_o3", 32'(out_data), 32'h0003);
        chk("bp_o3_t", 32'(out_dst), 32'd3);
        tick();
        chk("bp_count", 32'(op_count), 32'd3);
        chk("bp_drain", 32'(out_valid), 32'd0);

        // op_count wrap at 16 bits
        do_reset();
        drive(6'b101010, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 65535; i++) tick();
        idle();
        tick();
        tick();
        chk("wrap_max", 32'(op_count), 32'hFFFF);
        drive(6'b101010, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd0);
        tick();
        idle();
        tick();
        tick();
        chk("wrap_zero", 32'(op_count), 32'h0000);

        // reset with two ops in flight
        out_ready = 1'b0;
        drive(6'b000010, 16'h0004, 16'h0004, 1'b0, 1'b0, 3'd6);
        tick();
        drive(6'b000010, 16'h0005, 16'h0005, 1'b0, 1'b0, 3'd7);
        tick();
        idle();
        chk("mid_full", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_out_v", 32'(out_valid), 32'd0);
        chk("mid_en", 32'(alu_enable), 32'd0);
        chk("mid_count", 32'(op_count), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        chk("mid_no_ret", 32'(op_count), 32'd0);
        chk("mid_empty", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule
